// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with thresholds, occupancy count and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads through an output-stage register.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_W    = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_W    = AE_THRESH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  wr_acc, rd_acc, mem_we;
`ifdef SYNC_FIFO_FWFT_EN
    logic                  stage_free, mem_empty, load_mem, bypass;
`endif

    always_comb begin
        wr_acc  = w_en && !full_q;
        rd_acc  = r_en && !empty_q;
        count_d = count_q + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
        ovf_d   = (w_en && full_q) || (ovf_q && !clr_err);
        unf_d   = (r_en && empty_q) || (unf_q && !clr_err);
        af_d    = count_d >= AF_W;
        ae_d    = count_d <= AE_W;
`ifdef SYNC_FIFO_FWFT_EN
        // The output stage refills from memory first; a write into an otherwise empty FIFO bypasses memory.
        stage_free = empty_q || rd_acc;
        mem_empty  = wr_ptr_q == rd_ptr_q;
        load_mem   = stage_free && !mem_empty;
        bypass     = stage_free && mem_empty && wr_acc;
        mem_we     = wr_acc && !bypass;
        wr_ptr_d   = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, mem_we};
        rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, load_mem};
        data_out_d = load_mem ? mem[rd_ptr_q[ADDR_WIDTH-1:0]] : bypass ? data_in : data_out_q;
        empty_d    = stage_free && mem_empty && !wr_acc;
        full_d     = count_d == DEPTH_W;
`else
        mem_we     = wr_acc;
        wr_ptr_d   = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
        rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
        data_out_d = rd_acc ? mem[rd_ptr_q[ADDR_WIDTH-1:0]] : data_out_q;
        empty_d    = wr_ptr_d == rd_ptr_d;
        full_d     = (wr_ptr_d ^ rd_ptr_d) == DEPTH_W;
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign data_out     = data_out_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule
